// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_pkg
// Brief    : 640x480@60 default timing constants and sync decode boundaries.
// Revision : 1.0
// ============================================================================
package vga_timing_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam int CNT_MAX   = 1024;
    localparam int PIPE_MAX  = 7;

    // Idle value of the {hs, vs, blank} bundle: syncs inactive, blanking.
    localparam logic [2:0] SYNC_IDLE = 3'b110;

    function automatic logic in_window(input int v, input int lo, input int hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : vga_delay_line
// Brief    : Fixed-depth shift register with a synchronous reset value.
// Revision : 1.0
// ============================================================================
module vga_delay_line #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst, rst_val};
            assign dout     = din;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) r_stage[i] <= rst_val;
                end else begin
                    r_stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign dout = r_stage[DEPTH-1];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : vga_timing_gen
// Brief    : Free-running VGA scan counters, sync/blank decode and delayed copies.
// Revision : 1.0
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE   = vga_timing_pkg::H_ACTIVE,
    parameter int H_FP       = vga_timing_pkg::H_FP,
    parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
    parameter int H_BP       = vga_timing_pkg::H_BP,
    parameter int V_ACTIVE   = vga_timing_pkg::V_ACTIVE,
    parameter int V_FP       = vga_timing_pkg::V_FP,
    parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
    parameter int V_BP       = vga_timing_pkg::V_BP,
    parameter int PIPE_DELAY = 2
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       line_start,
    output logic       frame_start,
    output logic       hs_d,
    output logic       vs_d,
    output logic       blank_d
);
    import vga_timing_pkg::*;

    localparam int         c_h_total  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int         c_v_total  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] c_h_last   = 10'(c_h_total - 1);
    localparam logic [9:0] c_v_last   = 10'(c_v_total - 1);
    localparam int         c_hs_start = H_ACTIVE + H_FP;
    localparam int         c_hs_end   = c_hs_start + H_SYNC;
    localparam int         c_vs_start = V_ACTIVE + V_FP;
    localparam int         c_vs_end   = c_vs_start + V_SYNC;

    generate
        if (c_h_total > CNT_MAX || c_v_total > CNT_MAX) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
        if (PIPE_DELAY < 0 || PIPE_DELAY > PIPE_MAX) begin : g_bad_delay
            $error("vga_timing_gen: PIPE_DELAY must be within 0..7");
        end
    endgenerate

    logic [9:0] r_h, r_v;
    logic [9:0] w_h_next, w_v_next;
    logic       w_h_wrap;
    logic       w_hs, w_vs, w_blank;
    logic       r_hs, r_vs, r_blank, r_line_start, r_frame_start;
    logic [2:0] w_sync_d;

    // Decode the next counter values so every output lands in a register.
    always_comb begin
        w_h_wrap = (r_h == c_h_last);
        w_h_next = w_h_wrap ? 10'd0 : r_h + 10'd1;
        w_v_next = r_v;
        if (w_h_wrap) begin
            w_v_next = (r_v == c_v_last) ? 10'd0 : r_v + 10'd1;
        end
        w_hs    = !in_window(int'(w_h_next), c_hs_start, c_hs_end);
        w_vs    = !in_window(int'(w_v_next), c_vs_start, c_vs_end);
        w_blank = (int'(w_h_next) < H_ACTIVE) && (int'(w_v_next) < V_ACTIVE);
    end

    always_ff @(posedge vga_clk) begin
        if (reset) begin
            r_h           <= c_h_last;
            r_v           <= c_v_last;
            r_hs          <= SYNC_IDLE[2];
            r_vs          <= SYNC_IDLE[1];
            r_blank       <= SYNC_IDLE[0];
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_h           <= w_h_next;
            r_v           <= w_v_next;
            r_hs          <= w_hs;
            r_vs          <= w_vs;
            r_blank       <= w_blank;
            r_line_start  <= (w_h_next == 10'd0);
            r_frame_start <= (w_h_next == 10'd0) && (w_v_next == 10'd0);
        end
    end

    vga_delay_line #(
        .DEPTH (PIPE_DELAY),
        .WIDTH (3)
    ) u_sync_delay (
        .clk     (vga_clk),
        .rst     (reset),
        .rst_val (SYNC_IDLE),
        .din     ({r_hs, r_vs, r_blank}),
        .dout    (w_sync_d)
    );

    assign DrawX       = r_h;
    assign DrawY       = r_v;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign blank       = r_blank;
    assign line_start  = r_line_start;
    assign frame_start = r_frame_start;
    assign hs_d        = w_sync_d[2];
    assign vs_d        = w_sync_d[1];
    assign blank_d     = w_sync_d[0];

endmodule
`default_nettype wire
